// File: rtl/fft_bfly_r2_if.sv
// Stream bundle for the radix-2 butterfly: input pair + twiddle index,
// twiddle ROM address/reply, and the result stream.
//   slave  : butterfly side (consumes in_*, tw_*, out_ready; drives the rest)
//   master : environment side (upstream source, twiddle ROM, downstream sink)
interface fft_bfly_r2_if #(
    parameter int WIDTH    = 16,
    parameter int TW_WIDTH = 16,
    parameter int ADDR_W   = 3
);
    logic                       in_valid;
    logic                       in_ready;
    logic signed [WIDTH-1:0]    in_a_re;
    logic signed [WIDTH-1:0]    in_a_im;
    logic signed [WIDTH-1:0]    in_b_re;
    logic signed [WIDTH-1:0]    in_b_im;
    logic [ADDR_W-1:0]          in_k;
    logic [ADDR_W-1:0]          tw_addr;
    logic signed [TW_WIDTH-1:0] tw_re;
    logic signed [TW_WIDTH-1:0] tw_im;
    logic                       out_valid;
    logic                       out_ready;
    logic signed [WIDTH-1:0]    out_x0_re;
    logic signed [WIDTH-1:0]    out_x0_im;
    logic signed [WIDTH-1:0]    out_x1_re;
    logic signed [WIDTH-1:0]    out_x1_im;
    logic                       out_ovf;

    modport slave (
        input  in_valid, in_a_re, in_a_im, in_b_re, in_b_im, in_k,
        input  tw_re, tw_im, out_ready,
        output in_ready, tw_addr, out_valid,
        output out_x0_re, out_x0_im, out_x1_re, out_x1_im, out_ovf
    );

    modport master (
        output in_valid, in_a_re, in_a_im, in_b_re, in_b_im, in_k,
        output tw_re, tw_im, out_ready,
        input  in_ready, tw_addr, out_valid,
        input  out_x0_re, out_x0_im, out_x1_re, out_x1_im, out_ovf
    );
endinterface

// File: rtl/fft_bfly_r2.sv
// Pipelined radix-2 DIT butterfly: x0 = a + b*W^k, x1 = a - b*W^k.
// Optional 1/2 scaling (SCALE=1) or unscaled saturating output (SCALE=0).
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : fft_bfly_r2_if.slave -- input pair/index (valid/ready),
//                twiddle ROM address out / combinational reply in,
//                result stream (valid/ready) with saturation flag.
// Latency: a pair accepted at edge n is presented after edge n+3.
// Stall is global: every stage holds while the output is stalled.
module fft_bfly_r2 #(
    parameter int WIDTH    = 16,
    parameter int TW_WIDTH = 16,
    parameter int ADDR_W   = 3,
    parameter int SCALE    = 1
) (
    input logic          clk,
    input logic          rst_n,
    fft_bfly_r2_if.slave bus
);
    localparam int PW = WIDTH + TW_WIDTH;   // product width
    localparam int TW = WIDTH + 1;          // rotated operand width
    localparam int SW = WIDTH + 2;          // sum width

    localparam logic signed [PW:0]   RND  = (PW+1)'(1) <<< (TW_WIDTH - 2);
    localparam logic signed [SW-1:0] YMAX = SW'((1 <<< (WIDTH - 1)) - 1);
    localparam logic signed [SW-1:0] YMIN = SW'(-(1 <<< (WIDTH - 1)));

    logic adv;

    // S1 capture
    logic                       v1, k0_1;
    logic signed [WIDTH-1:0]    a1_re, a1_im, b1_re, b1_im;
    logic signed [TW_WIDTH-1:0] w1_re, w1_im;

    // S2 multiply
    logic                       v2, k0_2;
    logic signed [WIDTH-1:0]    a2_re, a2_im, b2_re, b2_im;
    logic signed [PW-1:0]       p_rr, p_ii, p_ri, p_ir;

    // S3 rotated operand
    logic                       v3;
    logic signed [WIDTH-1:0]    a3_re, a3_im;
    logic signed [TW-1:0]       t3_re, t3_im;

    // output register
    logic                       vo, ovf;
    logic signed [WIDTH-1:0]    x0_re, x0_im, x1_re, x1_im;

    logic signed [PW:0]         sum_re, sum_im;
    logic signed [TW-1:0]       t_re, t_im;
    logic signed [SW-1:0]       s0_re, s0_im, s1_re, s1_im;
    logic [WIDTH:0]             r0_re, r0_im, r1_re, r1_im;

    function automatic logic signed [SW-1:0] scale_s(input logic signed [SW-1:0] s);
        if (SCALE != 0)
            return SW'(((SW+1)'(s) + (SW+1)'(1)) >>> 1);
        else
            return s;
    endfunction

    // Returns {saturated, value}.
    function automatic logic [WIDTH:0] sat(input logic signed [SW-1:0] y);
        if (y > YMAX)
            return {1'b1, WIDTH'(YMAX)};
        else if (y < YMIN)
            return {1'b1, WIDTH'(YMIN)};
        else
            return {1'b0, WIDTH'(y)};
    endfunction

    assign adv          = !(vo && !bus.out_ready);
    assign bus.in_ready = adv;
    assign bus.tw_addr  = bus.in_k;

    // Combine split over two registers: rounding/shift of the products
    // (and the k=0 bypass, W^0 = +1 not being representable) before the
    // S3 register, add/sub/scale/saturate before the output register.
    always_comb begin
        sum_re = (PW+1)'(p_rr) - (PW+1)'(p_ii) + RND;
        sum_im = (PW+1)'(p_ri) + (PW+1)'(p_ir) + RND;
        if (k0_2) begin
            t_re = TW'(b2_re);
            t_im = TW'(b2_im);
        end else begin
            t_re = TW'(sum_re >>> (TW_WIDTH - 1));
            t_im = TW'(sum_im >>> (TW_WIDTH - 1));
        end
    end

    always_comb begin
        s0_re = SW'(a3_re) + SW'(t3_re);
        s0_im = SW'(a3_im) + SW'(t3_im);
        s1_re = SW'(a3_re) - SW'(t3_re);
        s1_im = SW'(a3_im) - SW'(t3_im);
        r0_re = sat(scale_s(s0_re));
        r0_im = sat(scale_s(s0_im));
        r1_re = sat(scale_s(s1_re));
        r1_im = sat(scale_s(s1_im));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1    <= 1'b0;
            k0_1  <= 1'b0;
            a1_re <= '0;
            a1_im <= '0;
            b1_re <= '0;
            b1_im <= '0;
            w1_re <= '0;
            w1_im <= '0;
            v2    <= 1'b0;
            k0_2  <= 1'b0;
            a2_re <= '0;
            a2_im <= '0;
            b2_re <= '0;
            b2_im <= '0;
            p_rr  <= '0;
            p_ii  <= '0;
            p_ri  <= '0;
            p_ir  <= '0;
            v3    <= 1'b0;
            a3_re <= '0;
            a3_im <= '0;
            t3_re <= '0;
            t3_im <= '0;
            vo    <= 1'b0;
            ovf   <= 1'b0;
            x0_re <= '0;
            x0_im <= '0;
            x1_re <= '0;
            x1_im <= '0;
        end else if (adv) begin
            v1    <= bus.in_valid;
            k0_1  <= (bus.in_k == ADDR_W'(0));
            a1_re <= bus.in_a_re;
            a1_im <= bus.in_a_im;
            b1_re <= bus.in_b_re;
            b1_im <= bus.in_b_im;
            w1_re <= bus.tw_re;
            w1_im <= bus.tw_im;

            v2    <= v1;
            k0_2  <= k0_1;
            a2_re <= a1_re;
            a2_im <= a1_im;
            b2_re <= b1_re;
            b2_im <= b1_im;
            p_rr  <= PW'(b1_re) * PW'(w1_re);
            p_ii  <= PW'(b1_im) * PW'(w1_im);
            p_ri  <= PW'(b1_re) * PW'(w1_im);
            p_ir  <= PW'(b1_im) * PW'(w1_re);

            v3    <= v2;
            a3_re <= a2_re;
            a3_im <= a2_im;
            t3_re <= t_re;
            t3_im <= t_im;

            vo    <= v3;
            if (v3) begin
                x0_re <= r0_re[WIDTH-1:0];
                x0_im <= r0_im[WIDTH-1:0];
                x1_re <= r1_re[WIDTH-1:0];
                x1_im <= r1_im[WIDTH-1:0];
                ovf   <= r0_re[WIDTH] | r0_im[WIDTH] | r1_re[WIDTH] | r1_im[WIDTH];
            end
        end
    end

    assign bus.out_valid = vo;
    assign bus.out_x0_re = x0_re;
    assign bus.out_x0_im = x0_im;
    assign bus.out_x1_re = x1_re;
    assign bus.out_x1_im = x1_im;
    assign bus.out_ovf   = ovf;
endmodule

// File: tb/tb_fft_bfly_r2.sv
// Bench for fft_bfly_r2: two instances (SCALE=1 and SCALE=0) driven with
// identical stimulus; directed vector table, reset/latency sequences and a
// backpressured random stream checked against a longint reference model.
module tb_fft_bfly_r2;
    localparam int W   = 16;
    localparam int TWW = 16;
    localparam int AW  = 3;

    // W^k = exp(-j*2*pi*k/16) in Q1.15; entry 0 is never used by the DUT.
    localparam int RRE[8] = '{32767, 30274, 23170, 12540, 0, -12540, -23170, -30274};
    localparam int RIM[8] = '{0, -12540, -23170, -30274, -32768, -30274, -23170, -12540};

    typedef struct packed {
        logic signed [15:0] x0_re;
        logic signed [15:0] x0_im;
        logic signed [15:0] x1_re;
        logic signed [15:0] x1_im;
        logic               ovf;
    } res_t;

    typedef struct {
        logic signed [15:0] a_re, a_im, b_re, b_im;
        logic [2:0]         k;
        res_t               e1;
        res_t               e0;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic               in_valid, out_ready;
    logic signed [15:0] a_re, a_im, b_re, b_im;
    logic [2:0]         k;

    int total = 0;
    int bad   = 0;

    fft_bfly_r2_if #(.WIDTH(W), .TW_WIDTH(TWW), .ADDR_W(AW)) bus1 ();
    fft_bfly_r2_if #(.WIDTH(W), .TW_WIDTH(TWW), .ADDR_W(AW)) bus0 ();

    fft_bfly_r2 #(.WIDTH(W), .TW_WIDTH(TWW), .ADDR_W(AW), .SCALE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1));
    fft_bfly_r2 #(.WIDTH(W), .TW_WIDTH(TWW), .ADDR_W(AW), .SCALE(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0));

    assign bus1.in_valid = in_valid;
    assign bus1.in_a_re  = a_re;
    assign bus1.in_a_im  = a_im;
    assign bus1.in_b_re  = b_re;
    assign bus1.in_b_im  = b_im;
    assign bus1.in_k     = k;
    assign bus1.out_ready = out_ready;
    assign bus0.in_valid = in_valid;
    assign bus0.in_a_re  = a_re;
    assign bus0.in_a_im  = a_im;
    assign bus0.in_b_re  = b_re;
    assign bus0.in_b_im  = b_im;
    assign bus0.in_k     = k;
    assign bus0.out_ready = out_ready;

    always_comb begin
        bus1.tw_re = 16'(RRE[bus1.tw_addr]);
        bus1.tw_im = 16'(RIM[bus1.tw_addr]);
        bus0.tw_re = 16'(RRE[bus0.tw_addr]);
        bus0.tw_im = 16'(RIM[bus0.tw_addr]);
    end

    function automatic res_t mkr(input int x0r, x0i, x1r, x1i, o);
        res_t r;
        r.x0_re = 16'(x0r);
        r.x0_im = 16'(x0i);
        r.x1_re = 16'(x1r);
        r.x1_im = 16'(x1i);
        r.ovf   = (o != 0);
        return r;
    endfunction

    function automatic vec_t mkv(input int ar, ai, br, bi, kk, input res_t e1, e0);
        vec_t v;
        v.a_re = 16'(ar);
        v.a_im = 16'(ai);
        v.b_re = 16'(br);
        v.b_im = 16'(bi);
        v.k    = 3'(kk);
        v.e1   = e1;
        v.e0   = e0;
        return v;
    endfunction

    function automatic res_t model(input logic signed [15:0] ar, ai, br, bi,
                                   input logic [2:0] kk, input bit scaled);
        longint lar = ar, lai = ai, lbr = br, lbi = bi;
        longint wr, wi, tr, ti, y;
        longint s[4];
        longint ys[4];
        res_t r;
        if (kk == 3'd0) begin
            tr = lbr;
            ti = lbi;
        end else begin
            wr = RRE[kk];
            wi = RIM[kk];
            tr = (lbr * wr - lbi * wi + 16384) >>> 15;
            ti = (lbr * wi + lbi * wr + 16384) >>> 15;
        end
        s[0] = lar + tr;
        s[1] = lai + ti;
        s[2] = lar - tr;
        s[3] = lai - ti;
        r.ovf = 1'b0;
        for (int i = 0; i < 4; i++) begin
            y = scaled ? ((s[i] + 1) >>> 1) : s[i];
            if (y > 32767) begin
                y = 32767;
                r.ovf = 1'b1;
            end else if (y < -32768) begin
                y = -32768;
                r.ovf = 1'b1;
            end
            ys[i] = y;
        end
        r.x0_re = 16'(ys[0]);
        r.x0_im = 16'(ys[1]);
        r.x1_re = 16'(ys[2]);
        r.x1_im = 16'(ys[3]);
        return r;
    endfunction

    function automatic res_t out1();
        res_t r;
        r.x0_re = bus1.out_x0_re;
        r.x0_im = bus1.out_x0_im;
        r.x1_re = bus1.out_x1_re;
        r.x1_im = bus1.out_x1_im;
        r.ovf   = bus1.out_ovf;
        return r;
    endfunction

    function automatic res_t out0();
        res_t r;
        r.x0_re = bus0.out_x0_re;
        r.x0_im = bus0.out_x0_im;
        r.x1_re = bus0.out_x1_re;
        r.x1_im = bus0.out_x1_im;
        r.ovf   = bus0.out_ovf;
        return r;
    endfunction

    task automatic check_res(input string name, input res_t act, input res_t exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got x0=(%0d,%0d) x1=(%0d,%0d) ovf=%0b, want x0=(%0d,%0d) x1=(%0d,%0d) ovf=%0b",
                     name, act.x0_re, act.x0_im, act.x1_re, act.x1_im, act.ovf,
                     exp.x0_re, exp.x0_im, exp.x1_re, exp.x1_im, exp.ovf);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic drive_vec(input vec_t v);
        a_re = v.a_re;
        a_im = v.a_im;
        b_re = v.b_re;
        b_im = v.b_im;
        k    = v.k;
    endtask

    // One beat into an idle pipeline; result must appear exactly after edge n+3.
    task automatic send_check(input vec_t v, input string tag);
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        drive_vec(v);
        #1;
        check_int({tag, "_in_ready"}, int'(bus1.in_ready), 1);
        check_int({tag, "_tw_addr"}, int'(bus1.tw_addr), int'(v.k));
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_int({tag, "_early1"}, int'(bus1.out_valid), 0);
        check_int({tag, "_early0"}, int'(bus0.out_valid), 0);
        @(negedge clk);
        check_int({tag, "_valid1"}, int'(bus1.out_valid), 1);
        check_int({tag, "_valid0"}, int'(bus0.out_valid), 1);
        check_res({tag, "_s1"}, out1(), v.e1);
        check_res({tag, "_s0"}, out0(), v.e0);
    endtask

    task automatic rand_beat();
        a_re = 16'($urandom);
        a_im = 16'($urandom);
        b_re = 16'($urandom);
        b_im = 16'($urandom);
        k    = 3'($urandom_range(7));
    endtask

    // Back-to-back stream of n beats with random out_ready; scoreboard order,
    // hold-while-stalled and in_ready-while-stalled checks.
    task automatic stream(input int n, input int ready_pct, input string tag);
        res_t q1[$];
        res_t q0[$];
        res_t h1, h0;
        int sent = 0, got1 = 0, got0 = 0, cyc = 0, extra = 0;
        bit held = 1'b0;
        bit acc = 1'b0;
        rand_beat();
        while ((got1 < n || got0 < n) && cyc < n * 12 + 100) begin
            @(negedge clk);
            if (acc) rand_beat();
            in_valid  = (sent < n);
            out_ready = ($urandom_range(99) < ready_pct);
            #1;
            if (held) begin
                check_res({tag, "_hold1"}, out1(), h1);
                check_res({tag, "_hold0"}, out0(), h0);
                check_int({tag, "_hold_valid"}, int'(bus1.out_valid), 1);
            end
            acc = in_valid && bus1.in_ready;
            if (acc) begin
                q1.push_back(model(a_re, a_im, b_re, b_im, k, 1'b1));
                q0.push_back(model(a_re, a_im, b_re, b_im, k, 1'b0));
                sent++;
            end
            if (bus1.out_valid && out_ready) begin
                if (q1.size() == 0) check_int({tag, "_unexpected1"}, 1, 0);
                else check_res({tag, "_x1"}, out1(), q1.pop_front());
                got1++;
            end
            if (bus0.out_valid && out_ready) begin
                if (q0.size() == 0) check_int({tag, "_unexpected0"}, 1, 0);
                else check_res({tag, "_x0"}, out0(), q0.pop_front());
                got0++;
            end
            held = bus1.out_valid && !out_ready;
            if (held) begin
                h1 = out1();
                h0 = out0();
                check_int({tag, "_in_ready_stall"}, int'(bus1.in_ready), 0);
            end
            cyc++;
        end
        in_valid = 1'b0;
        check_int({tag, "_count1"}, got1, n);
        check_int({tag, "_count0"}, got0, n);
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (bus1.out_valid || bus0.out_valid) extra++;
        end
        check_int({tag, "_no_extra"}, extra, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt[7];
        vec_t v;
        int stale;

        vt[0] = mkv(1000, 0, 2000, 0, 0, mkr(1500, 0, -500, 0, 0), mkr(3000, 0, -1000, 0, 0));
        vt[1] = mkv(1000, 0, 2000, 0, 4, mkr(500, -1000, 500, 1000, 0), mkr(1000, -2000, 1000, 2000, 0));
        vt[2] = mkv(32767, 0, 32767, 0, 0, mkr(32767, 0, 0, 0, 0), mkr(32767, 0, 0, 0, 1));
        vt[3] = mkv(0, 0, 0, 0, 0, mkr(0, 0, 0, 0, 0), mkr(0, 0, 0, 0, 0));
        vt[4] = mkv(-32768, -32768, -32768, -32768, 0,
                    mkr(-32768, -32768, 0, 0, 0), mkr(-32768, -32768, 0, 0, 1));
        vt[5] = mkv(0, 0, 10000, 0, 2, mkr(3536, -3535, -3535, 3536, 0),
                    mkr(7071, -7071, -7071, 7071, 0));
        vt[6] = mkv(100, -200, 0, 1000, 1, mkr(242, 362, -141, -562, 0),
                    mkr(483, 724, -283, -1124, 0));

        in_valid  = 1'b0;
        out_ready = 1'b1;
        a_re = '0;
        a_im = '0;
        b_re = '0;
        b_im = '0;
        k    = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check_int("rst_valid1", int'(bus1.out_valid), 0);
        check_int("rst_valid0", int'(bus0.out_valid), 0);
        check_res("rst_data1", out1(), mkr(0, 0, 0, 0, 0));
        check_res("rst_data0", out0(), mkr(0, 0, 0, 0, 0));
        rst_n = 1'b1;
        #1;
        check_int("rst_in_ready", int'(bus1.in_ready), 1);

        // Directed vector table
        for (int i = 0; i < 7; i++) begin
            send_check(vt[i], $sformatf("vec%0d", i));
        end

        // Backpressured burst of 8
        stream(8, 50, "bp");

        // Reset with 3 beats still in flight and one result at the output
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            in_valid  = 1'b1;
            out_ready = 1'b1;
            drive_vec(vt[i]);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #1;
        check_int("mid_pre_valid", int'(bus1.out_valid), 1);
        rst_n = 1'b0;
        #1;
        check_int("mid_rst_valid1", int'(bus1.out_valid), 0);
        check_int("mid_rst_valid0", int'(bus0.out_valid), 0);
        check_res("mid_rst_data1", out1(), mkr(0, 0, 0, 0, 0));
        check_res("mid_rst_data0", out0(), mkr(0, 0, 0, 0, 0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        stale = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus1.out_valid || bus0.out_valid) stale++;
        end
        check_int("mid_no_stale", stale, 0);
        v = mkv(-300, 700, 1200, -50, 0, mkr(450, 325, -750, 375, 0), mkr(900, 650, -1500, 750, 0));
        send_check(v, "post_rst");

        // Random sweep against the reference model
        stream(1000, 80, "sweep");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
